// File: rtl/dram_model.sv
// rtl/dram_model.sv - cycle-based single-bank 32-bit DRAM model with multiplexed row/column address.
// Optional macro DRAM_TIMING_CHECK_EN compiles in tRCD/tRP checking.
module dram_model #(
  parameter int ROW_W = 11,
  parameter int COL_W = 10,
  parameter int CL    = 5,
  parameter int T_RCD = 3,
  parameter int T_RP  = 3
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        CSn,
  input  logic        RASn,
  input  logic        CASn,
  input  logic [3:0]  WEn,
  input  logic [10:0] A,
  input  logic [31:0] D,
  output logic [31:0] Q,
  output logic        VALID
);

  localparam int AW    = ROW_W + COL_W;
  localparam int DEPTH = 1 << AW;

  logic [7:0] Memory_byte0 [0:DEPTH-1];
  logic [7:0] Memory_byte1 [0:DEPTH-1];
  logic [7:0] Memory_byte2 [0:DEPTH-1];
  logic [7:0] Memory_byte3 [0:DEPTH-1];

  logic             row_open;
  logic [ROW_W-1:0] row;
  logic [AW-1:0]    addr;
  logic [31:0]      rd_word;
  logic             cmd_act, cmd_pre, cmd_rd, cmd_wr;
  logic             rcd_ok, rp_ok, act_ok, do_rd, do_wr;
  logic [CL-2:0]    pipe_vld;
  logic [31:0]      pipe_data [0:CL-2];
  logic             unused_bits;

  assign cmd_act = !CSn && !RASn &&  CASn && (WEn == 4'hF);
  assign cmd_pre = !CSn && !RASn &&  CASn && (WEn != 4'hF);
  assign cmd_rd  = !CSn &&  RASn && !CASn && (WEn == 4'hF);
  assign cmd_wr  = !CSn &&  RASn && !CASn && (WEn != 4'hF);

  assign addr    = {row, A[COL_W-1:0]};
  assign rd_word = {Memory_byte3[addr], Memory_byte2[addr], Memory_byte1[addr], Memory_byte0[addr]};

`ifdef DRAM_TIMING_CHECK_EN
  localparam int TMAX = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int CW   = $clog2(TMAX + 1);

  // Cycles elapsed since the last accepted ACT / PRE, saturating at the limit.
  logic [CW-1:0] rcd_cnt, rp_cnt;

  assign rcd_ok = (rcd_cnt >= CW'(T_RCD));
  assign rp_ok  = (rp_cnt  >= CW'(T_RP));

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      rcd_cnt <= CW'(T_RCD);
      rp_cnt  <= CW'(T_RP);
    end else begin
      if (act_ok)
        rcd_cnt <= CW'(1);
      else if (!rcd_ok)
        rcd_cnt <= rcd_cnt + CW'(1);
      if (cmd_pre)
        rp_cnt <= CW'(1);
      else if (!rp_ok)
        rp_cnt <= rp_cnt + CW'(1);
      if (cmd_act && !rp_ok)
        $display("dram_model error: ACT within T_RP of PRE ignored");
      if ((cmd_rd || cmd_wr) && row_open && !rcd_ok)
        $display("dram_model error: READ/WRITE within T_RCD of ACT ignored");
    end
  end
  assign unused_bits = ^A;
`else
  assign rcd_ok      = 1'b1;
  assign rp_ok       = 1'b1;
  assign unused_bits = ^{A, 32'(T_RCD), 32'(T_RP)};
`endif

  assign act_ok = cmd_act && rp_ok;
  assign do_rd  = cmd_rd && row_open && rcd_ok;
  assign do_wr  = cmd_wr && row_open && rcd_ok;

  // Storage is never reset; only writes and hierarchical preload change it.
  always_ff @(posedge CK) begin
    if (do_wr) begin
      if (!WEn[0]) Memory_byte0[addr] <= D[7:0];
      if (!WEn[1]) Memory_byte1[addr] <= D[15:8];
      if (!WEn[2]) Memory_byte2[addr] <= D[23:16];
      if (!WEn[3]) Memory_byte3[addr] <= D[31:24];
    end
  end

  // Read data is captured at command time, so later writes cannot disturb it.
  always_ff @(posedge CK) begin
    pipe_data[0] <= rd_word;
    for (int i = 1; i < CL - 1; i++)
      pipe_data[i] <= pipe_data[i-1];
  end

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      pipe_vld <= '0;
      VALID    <= 1'b0;
      Q        <= '0;
      row_open <= 1'b0;
      row      <= '0;
    end else begin
      pipe_vld[0] <= do_rd;
      for (int i = 1; i < CL - 1; i++)
        pipe_vld[i] <= pipe_vld[i-1];
      VALID <= pipe_vld[CL-2];
      if (pipe_vld[CL-2])
        Q <= pipe_data[CL-2];

      if (act_ok) begin
        row      <= A[ROW_W-1:0];
        row_open <= 1'b1;
      end else if (cmd_pre) begin
        row_open <= 1'b0;
      end

      if ((cmd_rd || cmd_wr) && !row_open)
        $display("dram_model warning: READ/WRITE with no open row ignored");
    end
  end

endmodule

// File: tb/tb_dram_model.sv
// tb/tb_dram_model.sv - scoreboard bench for dram_model with a word-level reference model.
module tb_dram_model;
  localparam int CL    = 5;
  localparam int T_RCD = 3;
  localparam int T_RP  = 3;

  logic        CK = 1'b0;
  logic        RST = 1'b0;
  logic        CSn = 1'b1;
  logic        RASn = 1'b1;
  logic        CASn = 1'b1;
  logic [3:0]  WEn = 4'hF;
  logic [10:0] A = '0;
  logic [31:0] D = '0;
  logic [31:0] Q;
  logic        VALID;

  dram_model #(.ROW_W(11), .COL_W(10), .CL(CL), .T_RCD(T_RCD), .T_RP(T_RP)) dut (
    .CK(CK), .RST(RST), .CSn(CSn), .RASn(RASn), .CASn(CASn),
    .WEn(WEn), .A(A), .D(D), .Q(Q), .VALID(VALID)
  );

  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  bit          m_open = 0;
  logic [10:0] m_row = '0;
  int          m_act_edge = -1000;
  int          m_pre_edge = -1000;
  int          n_checks = 0;
  int          n_fail = 0;
  int          rows[4] = '{11'h100, 11'h2A5, 11'h7FF, 11'h003};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one command at the current negedge, update the reference model, advance to the next negedge.
  task automatic cmd(input bit csn, input bit ras, input bit cas, input logic [3:0] we,
                     input logic [10:0] a, input logic [31:0] d);
    int          edge_no;
    int          addr;
    logic [31:0] w;
    CSn = csn; RASn = ras; CASn = cas; WEn = we; A = a; D = d;
    edge_no = cyc + 1;
    if (!csn && !ras && cas) begin
      if (we == 4'hF) begin
        bit ok = 1;
`ifdef DRAM_TIMING_CHECK_EN
        ok = (edge_no - m_pre_edge) >= T_RP;
`endif
        if (ok) begin
          m_open = 1; m_row = a; m_act_edge = edge_no;
        end
      end else begin
        m_open = 0; m_pre_edge = edge_no;
      end
    end else if (!csn && ras && !cas && m_open) begin
      bit ok = 1;
`ifdef DRAM_TIMING_CHECK_EN
      ok = (edge_no - m_act_edge) >= T_RCD;
`endif
      addr = int'({m_row, a[9:0]});
      if (ok) begin
        if (we == 4'hF) begin
          sb.push_back('{data: model[addr], due: cyc + CL});
        end else begin
          w = model[addr];
          for (int i = 0; i < 4; i++)
            if (!we[i]) w[8*i +: 8] = d[8*i +: 8];
          model[addr] = w;
        end
      end
    end
    @(negedge CK);
  endtask

  task automatic nop();
    cmd(1'b1, 1'b1, 1'b1, 4'hF, '0, '0);
  endtask

  task automatic act(input logic [10:0] r);
    cmd(1'b0, 1'b0, 1'b1, 4'hF, r, '0);
  endtask

  task automatic pre();
    cmd(1'b0, 1'b0, 1'b1, 4'h0, '0, '0);
  endtask

  task automatic rd(input logic [9:0] c);
    cmd(1'b0, 1'b1, 1'b0, 4'hF, {1'b0, c}, '0);
  endtask

  task automatic wr(input logic [9:0] c, input logic [31:0] d, input logic [3:0] we);
    cmd(1'b0, 1'b1, 1'b0, we, {1'b0, c}, d);
  endtask

  task automatic preload(input logic [20:0] addr, input logic [31:0] w);
    dut.Memory_byte0[addr] = w[7:0];
    dut.Memory_byte1[addr] = w[15:8];
    dut.Memory_byte2[addr] = w[23:16];
    dut.Memory_byte3[addr] = w[31:24];
    model[int'(addr)] = w;
  endtask

  function automatic logic [31:0] lanes(input logic [20:0] addr);
    return {dut.Memory_byte3[addr], dut.Memory_byte2[addr], dut.Memory_byte1[addr], dut.Memory_byte0[addr]};
  endfunction

  // Reset held for one cycle; released at a negedge so the next command can follow at once.
  task automatic do_reset();
    RST = 1'b0;
    sb.delete();
    m_open = 0; m_act_edge = -1000; m_pre_edge = -1000;
    @(negedge CK);
    chk("reset_valid", {31'b0, VALID}, 32'h0);
    chk("reset_q", Q, 32'h0);
    RST = 1'b1;
  endtask

  // Monitor: compares every VALID cycle against the oldest expected read.
  initial begin
    exp_t e;
    forever begin
      @(posedge CK);
      #1;
      if (VALID) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {31'b0, VALID}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("read_data", Q, e.data);
          chk("read_latency", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        chk("missing_valid", {31'b0, VALID}, 32'h1);
      end
    end
  end

  initial begin
    int r;
    @(negedge CK);
    @(negedge CK);
    chk("por_valid", {31'b0, VALID}, 32'h0);
    chk("por_q", Q, 32'h0);
    RST = 1'b1;
    @(negedge CK);

    for (int ri = 0; ri < 4; ri++)
      for (int c = 0; c < 32; c++)
        preload({rows[ri], 10'(c)}, $urandom);
    preload(21'h40001, 32'h11223344);

    act(11'h100);
    repeat (T_RCD - 1) nop();
    wr(10'h000, 32'hDEADBEEF, 4'h0);
    nop();
    chk("full_write_lanes", lanes(21'h40000), 32'hDEADBEEF);
    rd(10'h000);
    wr(10'h001, 32'hAABBCCDD, 4'b1010);
    nop();
    chk("byte_mask_lanes", lanes(21'h40001), 32'h11BB33DD);
    rd(10'h001);
    repeat (CL + 2) nop();

    rd(10'h000); rd(10'h001); rd(10'h002);
    wr(10'h000, 32'h0BADF00D, 4'h0);
    repeat (CL + 2) nop();

    pre();
    repeat (T_RP - 1) nop();
    rd(10'h002);
    repeat (CL + 2) nop();
    act(11'h100);
    repeat (T_RCD - 1) nop();
    rd(10'h002);
    repeat (CL + 2) nop();

    pre();
    repeat (T_RP - 1) nop();
    act(11'h2A5);
    rd(10'h005);
    repeat (CL + 2) nop();

    act(11'h100);
    repeat (T_RCD - 1) nop();
    rd(10'h003);
    nop();
    pre();
    do_reset();
    act(11'h7FF);
    repeat (T_RCD - 1) nop();
    rd(10'h004);
    repeat (CL + 2) nop();

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: act(11'(rows[$urandom_range(0, 3)]));
        1: pre();
        2, 3, 4: rd(10'($urandom_range(0, 31)));
        5, 6: wr(10'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 14)));
        7: cmd(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 11'($urandom), $urandom);
        8: begin
          bit b = 1'($urandom);
          cmd(1'b0, b, b, 4'($urandom), 11'($urandom), $urandom);
        end
        default: nop();
      endcase
    end

    repeat (CL + 5) nop();
    while (sb.size() > 0) begin
      void'(sb.pop_front());
      chk("drain_timeout", 32'h0, 32'h1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_model.md
Name: dram_model

Overview:
- Cycle-based behavioural model of a single-bank, 32-bit-wide DRAM with a multiplexed row/column address bus, driven by the SoC's DRAM wrapper.
- Stores 2^21 words split into four byte lanes: Memory_byte0 (bits 7:0) through Memory_byte3 (bits 31:24).
- Benches preload and inspect the lanes hierarchically, e.g. golden results at word 0x40000.
- Supports row activate, column read with fixed CAS latency, byte-masked column write, and precharge.

Parameters:
- ROW_W, 11, row address width (taken from A[10:0]).
- COL_W, 10, column address width (taken from A[9:0]).
- CL, 5, CAS latency in CK cycles from READ command edge to the VALID cycle.
- T_RCD, 3, minimum cycles from ACT to the first READ or WRITE.
- T_RP, 3, minimum cycles from PRE to the next ACT.

Ports:
- CK  input  1  clock; all sampling on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- CSn  input  1  chip select, active low; commands are ignored while high.
- RASn  input  1  row address strobe, active low.
- CASn  input  1  column address strobe, active low.
- WEn  input  4  per-byte write enable, active low; bit i controls Memory_byte i.
- A  input  11  multiplexed row/column address.
- D  input  32  write data.
- Q  output  32  read data.
- VALID  output  1  high for exactly one cycle when Q holds read data.

Behaviour:
- Storage:
  - Memory_byte0..3 are each 2^21 x 8 arrays.
  - Word address is {row[10:0], col[9:0]}.
  - Reset never clears storage; contents come only from writes or hierarchical preload.
- Reset (RST=0, asynchronous):
  - Q=0, VALID=0.
  - Read pipeline flushed; row closed; timing counters saturated, so the next command is legal immediately.
- Command decode at posedge CK, only when CSn=0:
  - ACT: RASn=0, CASn=1, WEn=4'hF. Latches row=A[10:0], opens the row, restarts the T_RCD counter.
  - PRE: RASn=0, CASn=1, WEn!=4'hF. Closes the row, restarts the T_RP counter.
  - READ: RASn=1, CASn=0, WEn=4'hF. col=A[9:0]; queues a read of {row,col}.
  - WRITE: RASn=1, CASn=0, WEn!=4'hF. For each i with WEn[i]=0, Memory_byte i[{row,col}] <= D[8i+7:8i]. The write is visible to a READ issued in the next cycle.
  - RASn=0 with CASn=0, or RASn=1 with CASn=1: NOP.
- Read and write rules:
  - READ or WRITE with no open row: ignored, with a $display warning.
  - ACT while a row is open: re-latches the row (implicit precharge), no error.
- Read latency:
  - A READ accepted at edge n drives Q = word and VALID=1 during the cycle after edge n+CL-1, i.e. registered at edge n+CL-1 (CL=5 gives 5 cycles from command to VALID).
  - The word is sampled at command time, so a WRITE to the same address during the latency window does not alter the queued data.
  - Back-to-back READs on consecutive edges give VALID on consecutive cycles; pipeline depth is CL.
  - Q holds its last value when VALID=0.
- Pending reads continue to completion across PRE/ACT and while CSn=1.
- Address bits above the field widths are ignored. No wrap logic is needed, since full widths address the whole array.

Optional Feature:
- Macro DRAM_TIMING_CHECK_EN.
- When defined:
  - A READ or WRITE issued fewer than T_RCD cycles after ACT is ignored and prints a $display error.
  - An ACT issued fewer than T_RP cycles after PRE is ignored with an error.
  - The counters are compiled in.
- When undefined: no counters; every decoded command executes immediately; no timing messages.

Test Plan:
- Reset: assert RST=0 mid-read, with VALID due in 2 cycles -> VALID stays 0 after release; Q=0; the first command after release is accepted.
- Full write: ACT row 0x100; WRITE col 0x000, D=32'hDEADBEEF, WEn=0 -> Memory_byte3..0 at word 0x40000 = DE,AD,BE,EF. A READ then gives VALID exactly 5 cycles later with Q=32'hDEADBEEF.
- Byte mask: preload word 0x40001=32'h11223344; WRITE col 0x001, D=32'hAABBCCDD, WEn=4'b1010 -> word = 32'h11BB33DD.
- Back-to-back reads: READ cols 0,1,2 on three consecutive edges -> VALID high three consecutive cycles, with Q in command order.
- No open row: after PRE, a READ -> no VALID, warning printed. After ACT and T_RCD cycles, the same READ succeeds.
- DRAM_TIMING_CHECK_EN defined: READ one cycle after ACT -> ignored, no VALID. Undefined: same stimulus -> VALID after CL cycles.
